pipe_issue_arb: RTL and testbench
=================================

Name: pipe_issue_arb

Overview:
Round-robin issue scheduler that shares one stallable in-order pipeline among R requesters. It arbitrates requester valid/accept handshakes onto the pipeline input. It tags each issued op with its requester ID and enforces a per-requester cap on in-flight ops. It retires credits as tagged ops leave the pipeline output.

Parameters:
R, 4, number of requesters (2..16)
W, 32, payload data width
MAX_OUT, 2, max in-flight ops per requester (1..15)
IDW, $clog2(R), requester ID width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_vld  in  R  per-requester request valid
req_data  in  R*W  per-requester payload
req_accept  out  R  per-requester accept; one-hot or zero
pipe_in  out  IDW+W  issued op, {id, data}
pipe_in_vld  out  1  issue valid to pipeline
pipe_in_accept  in  1  pipeline accepts pipe_in this cycle
pipe_out_vld  in  1  op leaving pipeline this cycle; never stalled
pipe_out_id  in  IDW  ID field of the leaving op
rsp_vld  out  R  one-hot decode of retirement: pipe_out_vld & (pipe_out_id==i)
busy  out  1  any in-flight count nonzero
err_r  out  1  sticky: retirement seen for a requester with zero count

Behaviour:
- Reset (rst=0, async): rr_ptr_r=0, lock_r=0, lock_id_r=0, cnt_r[*]=0, err_r=0. Outputs: req_accept=0, pipe_in_vld=0, busy=0, rsp_vld=0.
- Eligible[i] = req_vld[i] & (cnt_r[i] < MAX_OUT).
- Grant selection is combinational, zero-cycle from req to pipe_in:
  - lock_r=1: grant = lock_id_r. Requesters must hold req_vld and req_data until accepted; no eligibility re-check.
  - lock_r=0: grant = first eligible index scanning rr_ptr_r, rr_ptr_r+1, ..., wrapping mod R. pipe_in_vld = any eligible.
- pipe_in = {grant, req_data[grant]}. req_accept[grant] = pipe_in_vld & pipe_in_accept.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED when pipe_in_vld & ~pipe_in_accept; lock_id_r <= grant.
  - LOCKED -> UNLOCKED on pipe_in_accept.
  - Any other case holds the current state.
- On accept: rr_ptr_r <= (grant==R-1) ? 0 : grant+1. Otherwise rr_ptr_r holds.
- Counters, per i, evaluated each cycle:
  - inc = accept to i; dec = pipe_out_vld & pipe_out_id==i.
  - inc & dec: unchanged. inc only: +1. dec only: -1.
  - dec with cnt_r[i]==0: count stays 0 and err_r <= 1 (sticky until reset).
  - A count never exceeds MAX_OUT; eligibility gating guarantees this.
- An issue and a retirement for the same requester in one cycle are legal. Eligibility uses the pre-update cnt_r, so there is no same-cycle credit bypass.
- pipe_out_id >= R with pipe_out_vld: ignored for counts, err_r <= 1.
- busy = OR over i of (cnt_r[i] != 0), driven from registers.
- Reset asserted mid-operation: all state clears immediately. In-flight ops still in the pipeline must be flushed by the pipeline's own reset. Any retirement arriving after reset sets err_r.

Decomposition:
- Shared package pipe_arb_pkg: id_t (IDW bits), cnt_t (4 bits), and the issue word struct {id_t id; logic [W-1:0] data} packed in that order.
- One sub-module, rr_pick: parameter R; inputs req[R] and ptr; outputs gnt_oh[R], gnt_id and any. It is purely combinational, so the scheduler holds all state.

Test Plan:
1. Reset, then all four requesters valid, pipe_in_accept=1 constantly, pipe_out_vld=0 -> grants 0,1,2,3,0,1,2,3 over 8 cycles. No further grants (all cnt=2). busy=1.
2. Requester 2 only valid, pipe_in_accept=0 for 3 cycles, then requester 0 also raises req_vld -> pipe_in id stays 2 (locked). The accept cycle issues id 2, and the next grant is 0.
3. MAX_OUT=2, requester 1 issues 2 ops, then pipe_out_vld with id 1 retires in the same cycle as req 1's third request -> third request is not granted that cycle. It is granted the following cycle, and cnt[1] ends at 2.
4. cnt[3]=1, requester 3 accepted in the same cycle pipe_out_vld id 3 arrives -> cnt[3] stays 1, rsp_vld=4'b1000.
5. pipe_out_vld with id 0 while cnt[0]=0 -> err_r=1 next cycle and remains 1. cnt[0]=0.
6. Async rst asserted mid-burst while locked -> outputs clear without a clock edge. After release, the first grant starts from requester 0.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared types for the pipeline issue arbiter.
// Issue word layout is {id, data}, id in the MSBs.
package pipe_arb_pkg;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int IDW_D = $clog2(NREQ);

  typedef logic [IDW_D-1:0] id_t;
  typedef logic [3:0]       cnt_t;

  typedef struct packed {
    id_t           id;
    logic [DW-1:0] data;
  } issue_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one picker: scans req from ptr upward, wrapping at R.
// Purely combinational; the caller owns the pointer.
module rr_pick #(
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   gnt_oh,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  int             idx;
  logic [IDW-1:0] w_idx;

  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    w_idx  = '0;
    for (int k = 0; k < R; k++) begin
      idx = int'(ptr) + k;
      if (idx >= R) idx = idx - R;
      w_idx = IDW'(idx);
      if (!any && req[w_idx]) begin
        any           = 1'b1;
        gnt_oh[w_idx] = 1'b1;
        gnt_id        = w_idx;
      end
    end
  end

endmodule

// File: rtl/pipe_issue_arb.sv
// Round-robin issue scheduler sharing one stallable pipeline among
// R requesters, with per-requester in-flight credit limits.
module pipe_issue_arb
  import pipe_arb_pkg::*;
#(
  parameter  int R       = 4,
  parameter  int W       = 32,
  parameter  int MAX_OUT = 2,
  localparam int IDW     = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_vld,
  input  logic [R*W-1:0]   req_data,
  output logic [R-1:0]     req_accept,
  output logic [IDW+W-1:0] pipe_in,
  output logic             pipe_in_vld,
  input  logic             pipe_in_accept,
  input  logic             pipe_out_vld,
  input  logic [IDW-1:0]   pipe_out_id,
  output logic [R-1:0]     rsp_vld,
  output logic             busy,
  output logic             err_r
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_e;

  lock_e          r_state;
  lock_e          w_state_nxt;
  logic [IDW-1:0] r_lock_id;
  logic [IDW-1:0] r_rr_ptr;
  cnt_t           r_cnt [R];
  logic           r_err;

  logic [R-1:0]   w_elig;
  logic [R-1:0]   w_pick_oh;
  logic [IDW-1:0] w_pick_id;
  logic           w_pick_any;
  logic [IDW-1:0] w_grant;
  logic [R-1:0]   w_grant_oh;
  logic           w_vld;
  logic           w_fire;
  logic [W-1:0]   w_data;
  logic           w_oid_ok;
  logic [R-1:0]   w_zero;
  logic           w_err_set;
  logic           w_locked;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < R; i++)
      w_elig[i] = req_vld[i] & (r_cnt[i] < cnt_t'(MAX_OUT));
  end

  rr_pick #(.R(R)) u_pick (
    .req    (w_elig),
    .ptr    (r_rr_ptr),
    .gnt_oh (w_pick_oh),
    .gnt_id (w_pick_id),
    .any    (w_pick_any)
  );

  // A stalled grant stays pinned until the pipeline takes it.
  assign w_locked   = (r_state == LOCKED);
  assign w_grant    = w_locked ? r_lock_id : w_pick_id;
  assign w_grant_oh = w_locked ? (R'(1) << r_lock_id) : w_pick_oh;
  assign w_vld      = rst & (w_locked | w_pick_any);
  assign w_fire     = w_vld & pipe_in_accept;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < R; i++)
      if (w_grant == IDW'(i)) w_data = req_data[i*W +: W];
  end

  assign pipe_in     = {w_grant, w_data};
  assign pipe_in_vld = w_vld;
  assign req_accept  = w_fire ? w_grant_oh : '0;

  assign w_oid_ok = {1'b0, pipe_out_id} < (IDW+1)'(R);

  always_comb begin
    rsp_vld = '0;
    w_zero  = '0;
    busy    = 1'b0;
    for (int i = 0; i < R; i++) begin
      rsp_vld[i] = rst & pipe_out_vld & (pipe_out_id == IDW'(i));
      w_zero[i]  = (r_cnt[i] == '0);
      busy       = busy | ~w_zero[i];
    end
  end

  assign w_err_set = (|(rsp_vld & w_zero)) | (pipe_out_vld & ~w_oid_ok);
  assign err_r     = r_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      UNLOCKED: if (w_vld & ~pipe_in_accept) w_state_nxt = LOCKED;
      LOCKED:   if (pipe_in_accept) w_state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= UNLOCKED;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_locked && w_vld && !pipe_in_accept)
        r_lock_id <= w_grant;
      if (w_fire)
        r_rr_ptr <= (w_grant == IDW'(R-1)) ? '0 : w_grant + 1'b1;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < R; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < R; i++) begin
        if (rsp_vld[i] && w_zero[i])
          r_cnt[i] <= '0;
        else if (req_accept[i] && !rsp_vld[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (rsp_vld[i] && !req_accept[i])
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_arb.sv
// Directed plus randomized bench for pipe_issue_arb against a
// credit/queue-level reference model.
module tb_pipe_issue_arb;
  import pipe_arb_pkg::*;

  localparam int R   = 4;
  localparam int W   = 32;
  localparam int MO  = 2;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [R-1:0]     req_vld;
  logic [R*W-1:0]   req_data;
  logic [R-1:0]     req_accept;
  logic [IDW+W-1:0] pipe_in;
  logic             pipe_in_vld;
  logic             pipe_in_accept;
  logic             pipe_out_vld;
  logic [IDW-1:0]   pipe_out_id;
  logic [R-1:0]     rsp_vld;
  logic             busy;
  logic             err_r;

  pipe_issue_arb #(.R(R), .W(W), .MAX_OUT(MO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_vld        (req_vld),
    .req_data       (req_data),
    .req_accept     (req_accept),
    .pipe_in        (pipe_in),
    .pipe_in_vld    (pipe_in_vld),
    .pipe_in_accept (pipe_in_accept),
    .pipe_out_vld   (pipe_out_vld),
    .pipe_out_id    (pipe_out_id),
    .rsp_vld        (rsp_vld),
    .busy           (busy),
    .err_r          (err_r)
  );

  always #5 clk = ~clk;

  int m_cnt [R];
  int m_ptr;
  bit m_lock;
  int m_lid;
  bit m_err;
  int n_chk;
  int n_fail;

  function automatic void model_reset();
    for (int i = 0; i < R; i++) m_cnt[i] = 0;
    m_ptr  = 0;
    m_lock = 0;
    m_lid  = 0;
    m_err  = 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    int i;
    if (m_lock) return m_lid;
    for (int k = 0; k < R; k++) begin
      i = (m_ptr + k) % R;
      if (req_vld[i] && m_cnt[i] < MO) return i;
    end
    return -1;
  endfunction

  function automatic int total_cnt();
    int s = 0;
    for (int i = 0; i < R; i++) s += m_cnt[i];
    return s;
  endfunction

  task automatic cycle(input logic [R-1:0] v, input bit acc,
                       input bit ov, input int oid, output int gobs);
    int     g;
    bit     fire, inc, dec;
    issue_t iw;
    for (int i = 0; i < R; i++)
      if (!(m_lock && i == m_lid)) req_data[i*W +: W] = $urandom;
    req_vld        = v;
    pipe_in_accept = acc;
    pipe_out_vld   = ov;
    pipe_out_id    = IDW'(oid);
    #4;
    g    = exp_grant();
    iw   = pipe_in;
    gobs = pipe_in_vld ? int'(iw.id) : -1;
    chk("pipe_in_vld", 64'(pipe_in_vld), 64'(g >= 0));
    if (g >= 0) begin
      chk("pipe_in_id", 64'(iw.id), 64'(g));
      chk("pipe_in_data", 64'(iw.data), 64'(req_data[g*W +: W]));
    end
    chk("req_accept", 64'(req_accept),
        (g >= 0 && acc) ? (64'd1 << g) : 64'd0);
    chk("rsp_vld", 64'(rsp_vld), ov ? (64'd1 << oid) : 64'd0);
    chk("busy", 64'(busy), 64'(total_cnt() != 0));
    chk("err_r", 64'(err_r), 64'(m_err));
    @(posedge clk);
    fire = (g >= 0) && acc;
    for (int i = 0; i < R; i++) begin
      inc = fire && g == i;
      dec = ov && oid == i;
      if (dec && m_cnt[i] == 0) m_err = 1;
      else if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) m_cnt[i]--;
    end
    if (!m_lock && g >= 0 && !acc) begin
      m_lock = 1;
      m_lid  = g;
    end else if (m_lock && acc) begin
      m_lock = 0;
    end
    if (fire) m_ptr = (g + 1) % R;
    #1;
  endtask

  task automatic drain();
    int g;
    for (int i = 0; i < R; i++)
      while (m_cnt[i] > 0) cycle('0, 1'b0, 1'b1, i, g);
  endtask

  initial begin
    int           g;
    logic [R-1:0] v;
    bit           acc, ov;
    int           oid, pick;
    n_chk          = 0;
    n_fail         = 0;
    model_reset();
    rst            = 1'b0;
    req_vld        = '1;
    req_data       = '0;
    pipe_in_accept = 1'b1;
    pipe_out_vld   = 1'b1;
    pipe_out_id    = '0;
    #12;
    chk("rst_pipe_in_vld", 64'(pipe_in_vld), 64'd0);
    chk("rst_req_accept", 64'(req_accept), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_r), 64'd0);
    req_vld      = '0;
    pipe_out_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: full round robin until every requester holds MAX_OUT credits
    for (int k = 0; k < 8; k++) begin
      cycle('1, 1'b1, 1'b0, 0, g);
      chk("t1_grant_seq", 64'(g), 64'(k % R));
    end
    cycle('1, 1'b1, 1'b0, 0, g);
    chk("t1_no_grant", 64'(g), 64'(-1));
    chk("t1_busy", 64'(busy), 64'd1);
    drain();

    // 2: stalled grant stays locked to requester 2
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0100, 1'b0, 1'b0, 0, g);
      chk("t2_lock_id", 64'(g), 64'd2);
    end
    cycle(4'b0101, 1'b0, 1'b0, 0, g);
    chk("t2_still_2", 64'(g), 64'd2);
    cycle(4'b0101, 1'b1, 1'b0, 0, g);
    chk("t2_issue_2", 64'(g), 64'd2);
    cycle(4'b0001, 1'b1, 1'b0, 0, g);
    chk("t2_next_0", 64'(g), 64'd0);
    drain();

    // 3: no same-cycle credit bypass
    cycle(4'b0010, 1'b1, 1'b0, 0, g);
    cycle(4'b0010, 1'b1, 1'b0, 0, g);
    cycle(4'b0010, 1'b1, 1'b1, 1, g);
    chk("t3_blocked", 64'(g), 64'(-1));
    cycle(4'b0010, 1'b1, 1'b0, 0, g);
    chk("t3_granted", 64'(g), 64'd1);
    cycle(4'b0010, 1'b1, 1'b0, 0, g);
    chk("t3_cnt_full", 64'(g), 64'(-1));
    drain();

    // 4: issue and retire for requester 3 in one cycle
    cycle(4'b1000, 1'b1, 1'b0, 0, g);
    cycle(4'b1000, 1'b1, 1'b1, 3, g);
    chk("t4_grant", 64'(g), 64'd3);
    cycle(4'b1000, 1'b1, 1'b0, 0, g);
    chk("t4_cnt1", 64'(g), 64'd3);
    cycle(4'b1000, 1'b1, 1'b0, 0, g);
    chk("t4_cnt2", 64'(g), 64'(-1));
    drain();

    // 5: retirement without credit
    cycle('0, 1'b0, 1'b1, 0, g);
    cycle('0, 1'b0, 1'b0, 0, g);
    chk("t5_err", 64'(err_r), 64'd1);
    chk("t5_idle", 64'(busy), 64'd0);
    cycle('0, 1'b0, 1'b0, 0, g);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      v = R'($urandom);
      if (m_lock) v[m_lid] = 1'b1;
      acc  = ($urandom % 10) < 7;
      ov   = 1'b0;
      oid  = 0;
      pick = $urandom % R;
      if (($urandom % 2) == 0 && m_cnt[pick] > 0) begin
        ov  = 1'b1;
        oid = pick;
      end
      cycle(v, acc, ov, oid, g);
    end

    // 6: asynchronous reset while locked
    drain();
    cycle('1, 1'b1, 1'b0, 0, g);
    cycle('1, 1'b0, 1'b0, 0, g);
    req_vld        = '1;
    pipe_in_accept = 1'b1;
    pipe_out_vld   = 1'b1;
    pipe_out_id    = IDW'(m_lid);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_pipe_in_vld", 64'(pipe_in_vld), 64'd0);
    chk("t6_req_accept", 64'(req_accept), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("t6_err", 64'(err_r), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    pipe_out_vld = 1'b0;
    rst          = 1'b1;
    cycle('1, 1'b1, 1'b0, 0, g);
    chk("t6_first_grant", 64'(g), 64'd0);
    cycle('1, 1'b1, 1'b0, 0, g);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
